// File: rtl/paddle_control.sv
// rtl/paddle_control.sv - debounced, accelerating, clamped paddle position generator
module paddle_control #(
    parameter int MAXX      = 320,
    parameter int PD_LEN    = 20,
    parameter int DEB_CYC   = 16,
    parameter int TICK      = 10000,
    parameter int ACC_STEPS = 8,
    parameter int MAX_SHIFT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       center,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [9:0] pd_x,
    output logic [1:0] pd_dir,
    output logic [1:0] pd_speed
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TW = $clog2(TICK + 1);
    localparam int SW = $clog2(ACC_STEPS + 1);

    localparam logic [9:0]  X_MID  = 10'(MAXX / 2);
    localparam logic [9:0]  X_HI   = 10'(MAXX - PD_LEN);
    localparam logic [9:0]  X_LO   = 10'(PD_LEN);
    localparam logic [10:0] X_HI_W = 11'(MAXX - PD_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LEFT  = 2'b01,
        ST_RIGHT = 2'b10,
        ST_BLOCK = 2'b11
    } state_t;

    // index 0 is the left button, index 1 the right button
    logic [1:0]    sync1, sync2, deb;
    logic [DW-1:0] deb_cnt [2];

    state_t        state, state_next;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] step_cnt;
    logic [1:0]    shift;
    logic          step, state_chg, moving;

    logic [9:0]    step_px;
    logic [10:0]   right_sum, left_lim;
    logic [9:0]    left_diff, x_right, x_left;

    // two-flop synchroniser for the raw buttons
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_r, btn_l};
            sync2 <= sync1;
        end
    end

    // accept a synced level only after it has differed for DEB_CYC samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb        <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // direction FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // next direction from the debounced buttons; center/disable force idle
    always_comb begin
        state_next = ST_IDLE;
        if (!center && enable) begin
            case (deb)
                2'b11:   state_next = ST_BLOCK;
                2'b01:   state_next = ST_LEFT;
                2'b10:   state_next = ST_RIGHT;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign step      = (tick_cnt == TW'(TICK - 1));
    assign state_chg = (state_next != state);
    assign moving    = (state == ST_LEFT) || (state == ST_RIGHT);

    // step timer restarts on every direction change
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                tick_cnt <= '0;
        else if (state_chg || step) tick_cnt <= '0;
        else                       tick_cnt <= tick_cnt + 1'b1;
    end

    // speed doubles every ACC_STEPS steps held in one direction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
            shift    <= '0;
        end else if (state_chg) begin
            step_cnt <= '0;
            shift    <= '0;
        end else if (step && moving) begin
            if (step_cnt == SW'(ACC_STEPS - 1)) begin
                step_cnt <= '0;
                if (shift != 2'(MAX_SHIFT)) shift <= shift + 1'b1;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // clamped candidate positions, computed one bit wider so nothing wraps
    always_comb begin
        step_px   = 10'd1 << shift;
        right_sum = {1'b0, pd_x} + {1'b0, step_px};
        left_lim  = {1'b0, X_LO} + {1'b0, step_px};
        left_diff = pd_x - step_px;
        x_right   = (right_sum > X_HI_W) ? X_HI : right_sum[9:0];
        x_left    = ({1'b0, pd_x} < left_lim) ? X_LO : left_diff;
    end

    // position register: center wins over a coincident step
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pd_x <= X_MID;
        end else if (center) begin
            pd_x <= X_MID;
        end else if (enable && step) begin
            if (state == ST_LEFT)       pd_x <= x_left;
            else if (state == ST_RIGHT) pd_x <= x_right;
        end
    end

    assign pd_dir   = state;
    assign pd_speed = shift;

endmodule

// File: doc/paddle_control.md
# paddle_control

Paddle position generator that sits directly upstream of the game state controller. It turns the raw left/right push-buttons into a clean 10-bit paddle centre coordinate `pd_x`, which the state controller consumes for ball placement and paddle collision. Inputs are synchronised and debounced, then drive a direction FSM with a fixed-rate step timer. A held button accelerates the paddle, and its position is clamped to the play field.

## Interface
Parameters:
- `MAXX`, 320, play-field width in pixels.
- `PD_LEN`, 20, paddle half-length; legal `pd_x` range is [`PD_LEN`, `MAXX-PD_LEN`].
- `DEB_CYC`, 16, consecutive stable samples required to accept a button level.
- `TICK`, 10000, clock cycles per movement step.
- `ACC_STEPS`, 8, steps taken at one speed before the speed doubles.
- `MAX_SHIFT`, 2, maximum speed exponent; step size is `1<<shift` pixels.

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: paddle may move; driven high by the state controller during WAIT/PLAY.
- `center` in 1: synchronous one-cycle pulse; recentres the paddle.
- `btn_l` in 1: raw left button, asynchronous, active-high.
- `btn_r` in 1: raw right button, asynchronous, active-high.
- `pd_x` out 10: paddle centre x coordinate.
- `pd_dir` out 2: current motion; 00 idle, 01 left, 10 right, 11 blocked (both buttons held).
- `pd_speed` out 2: current speed exponent `shift`.

## Operation
- **Synchroniser:** each button passes through 2 flip-flops before any other use.
- **Debouncer:** one counter per button. The counter clears whenever the synced level equals the debounced level. Otherwise it increments. When it reaches `DEB_CYC`, the debounced level takes the synced level and the counter clears.
- **FSM states:** IDLE, LEFT, RIGHT, BLOCK. Next state is chosen from the debounced buttons (`dl`, `dr`):
  - `dl` & `dr`: BLOCK.
  - `dl` only: LEFT.
  - `dr` only: RIGHT.
  - neither: IDLE.
- **enable low or center high:** FSM forced to IDLE. `enable` low holds `pd_x`; `center` loads `pd_x` with `MAXX/2`. `center` has priority over `enable`.
- **Tick counter:** counts 0..`TICK-1` and wraps. Its terminal count produces a one-cycle `step` strobe. The counter clears on every state change, so the first move happens `TICK` cycles after entering LEFT or RIGHT.
- **Speed:**
  - `shift` and the step counter clear on any state change, including a direct LEFT↔RIGHT reversal.
  - Each `step` in LEFT or RIGHT increments the step counter.
  - When the step counter reaches `ACC_STEPS`, it clears and `shift` increments, saturating at `MAX_SHIFT`.
  - The new `shift` applies from the next step.
- **Move arithmetic:** done in 11 bits with no wrap-around.
  - RIGHT: `pd_x + (1<<shift)`, clamped to `MAXX-PD_LEN`.
  - LEFT: if `pd_x < PD_LEN + (1<<shift)`, result is `PD_LEN`; otherwise `pd_x - (1<<shift)`.
- **At a clamp edge:** the FSM stays in LEFT/RIGHT and speed keeps accumulating, but `pd_x` does not change.
- **IDLE and BLOCK:** no movement.

## Timing
- **Reset values (asynchronous, while `reset`=0):**
  - `pd_x`=`MAXX/2` (160), `pd_dir`=00, `pd_speed`=0.
  - Synchronisers 0, debounced levels 0, all counters 0, FSM in IDLE.
- **Button to FSM latency:** the FSM state changes `2+DEB_CYC+1` clock edges after a clean button edge. A synced glitch shorter than `DEB_CYC` cycles has no effect.
- **Step to output:** `pd_x` updates on the same edge on which `step` is registered. `pd_x` is registered and changes at most once per `TICK` cycles.
- **Output registration:** `pd_dir` and `pd_speed` are registered and reflect the current FSM state and `shift`.
- **center:** takes effect on the next edge. A `center` that coincides with a `step` wins, so `pd_x`=160.
- **Reset release:** releasing `reset` mid-operation restarts from the reset values. No button state survives reset.

## Test plan
Simulation parameters: `TICK`=4, `DEB_CYC`=3, `ACC_STEPS`=2, `MAX_SHIFT`=2, `enable`=1.
- **Reset:** pulse `reset` low asynchronously between clock edges → `pd_x`=160, `pd_dir`=00, `pd_speed`=0 immediately.
- **Accelerating right:** hold `btn_r`.
  - `pd_dir`=10 after 6 cycles.
  - `pd_x` then steps every 4 cycles: 161, 162, 164, 166, 170, 174, ...
  - `pd_speed` goes 0→1→2.
- **Right clamp:** continue holding `btn_r` → `pd_x` saturates at exactly 300 and stays there. Release `btn_r` → `pd_dir`=00, `pd_speed`=0.
- **Blocking and glitches:**
  - With `pd_x`=200, press `btn_l` and `btn_r` together → `pd_dir`=11 and `pd_x` remains 200.
  - A 2-cycle `btn_l` glitch from idle → no state change.
- **Left clamp from near edge:** from `pd_x`=23 at `shift`=2 (`pd_x`=23, the FSM already in LEFT, `shift`=2 via a preceding left hold), hold `btn_l` → next step gives 20, not 19, and `pd_x` stays at 20 thereafter.
- **center and enable:**
  - While moving, pulse `center` → `pd_x`=160 and `pd_dir`=00 next cycle.
  - Deassert `enable` while `btn_r` is held → `pd_x` frozen and `pd_dir`=00.
  - Reassert `enable` → the first move comes 4 cycles later at +1.
